// File: rtl/pixel_byte_packer_if.sv
// Pixel-side and byte-side handshake bundle for pixel_byte_packer.
// The packer sits on the slave modport; the pixel source and byte sink drive the master side.
interface pixel_byte_packer_if;
  logic [5:0]  data_type_i;
  logic [2:0]  pixel_per_clk_i;
  logic [95:0] pixel_data_i;
  logic [3:0]  pixel_data_valid_i;
  logic        pixel_ready_o;
  logic        flush_i;
  logic [31:0] byte_data_o;
  logic [3:0]  byte_data_valid_o;
  logic        byte_ready_i;
  logic        busy_o;
  logic        error_o;

  modport slave (
    input  data_type_i, pixel_per_clk_i, pixel_data_i, pixel_data_valid_i,
    input  flush_i, byte_ready_i,
    output pixel_ready_o, byte_data_o, byte_data_valid_o, busy_o, error_o
  );

  modport master (
    output data_type_i, pixel_per_clk_i, pixel_data_i, pixel_data_valid_i,
    output flush_i, byte_ready_i,
    input  pixel_ready_o, byte_data_o, byte_data_valid_o, busy_o, error_o
  );
endinterface

// File: rtl/pixel_byte_packer.sv
// Packs 1/2/4 pixel lanes per clock into a 4-byte CSI-2 payload stream through a
// byte FIFO, with per-type byte ordering, format lock and explicit end-of-line flush.
module pixel_byte_packer #(
  parameter int BUF_BYTES = 16
) (
  input logic                pixel_clk_i,
  input logic                reset_i,
  pixel_byte_packer_if.slave bus
);
  localparam int FW = $clog2(BUF_BYTES + 1);
  localparam int AW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam logic [5:0] DT_YUV422 = 6'h1E;
  localparam logic [5:0] DT_RGB888 = 6'h24;
  localparam logic [5:0] DT_RGB565 = 6'h22;
  localparam logic [5:0] DT_RAW8   = 6'h2A;
  localparam logic [5:0] DT_RAW10  = 6'h2B;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state_p0, state_nxt;
  logic [7:0]    buf_p0 [BUF_BYTES];
  logic [7:0]    buf_nxt [BUF_BYTES];
  logic [FW-1:0] fill_p0, fill_nxt, base;
  logic          ready_p0, err_p0, lock_vld_p0;
  logic [5:0]    lock_type_p0, dt;

  logic [3:0]  lane_mask, strb, out_vld, n_push;
  logic [2:0]  nlanes, pop;
  logic        ppc_ok, type_ok, contig, lock_ok, raw10_ok, present, accept, drop;
  logic [23:0] lane [4];
  logic [7:0]  beat_bytes [12];

  assign dt = bus.data_type_i;

  // Beat qualification: which lanes count and whether the beat is legal
  always_comb begin
    ppc_ok    = 1'b1;
    lane_mask = 4'b1111;
    case (bus.pixel_per_clk_i)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd4:    lane_mask = 4'b1111;
      default: ppc_ok = 1'b0;
    endcase
    strb    = bus.pixel_data_valid_i & lane_mask;
    present = |strb;
    nlanes  = 3'd0;
    contig  = 1'b1;
    case (strb)
      4'b0001: nlanes = 3'd1;
      4'b0011: nlanes = 3'd2;
      4'b0111: nlanes = 3'd3;
      4'b1111: nlanes = 3'd4;
      default: contig = 1'b0;
    endcase
    type_ok  = dt inside {DT_YUV422, DT_RGB888, DT_RGB565, DT_RAW8, DT_RAW10};
    lock_ok  = !lock_vld_p0 || (dt == lock_type_p0);
    raw10_ok = (dt != DT_RAW10) || (strb == 4'hF);
    accept   = ready_p0 && present && ppc_ok && type_ok && contig && lock_ok && raw10_ok;
    drop     = ready_p0 && present && !(ppc_ok && type_ok && contig && lock_ok && raw10_ok);
  end

  // Byte ordering per data type; slots beyond n_push are never appended
  always_comb begin
    for (int k = 0; k < 4; k++) lane[k] = bus.pixel_data_i[24*k +: 24];
    for (int i = 0; i < 12; i++) beat_bytes[i] = 8'h00;
    n_push = 4'd0;
    case (dt)
      DT_RAW8: begin
        for (int k = 0; k < 4; k++) beat_bytes[k] = lane[k][7:0];
        n_push = {1'b0, nlanes};
      end
      DT_RGB565, DT_YUV422: begin
        for (int k = 0; k < 4; k++) begin
          beat_bytes[2*k]   = lane[k][7:0];
          beat_bytes[2*k+1] = lane[k][15:8];
        end
        n_push = {nlanes, 1'b0};
      end
      DT_RGB888: begin
        for (int k = 0; k < 4; k++)
          for (int j = 0; j < 3; j++) beat_bytes[3*k+j] = lane[k][8*j +: 8];
        n_push = {1'b0, nlanes} + {nlanes, 1'b0};
      end
      DT_RAW10: begin
        for (int k = 0; k < 4; k++) beat_bytes[k] = lane[k][9:2];
        beat_bytes[4] = {lane[3][1:0], lane[2][1:0], lane[1][1:0], lane[0][1:0]};
        n_push = 4'd5;
      end
      default: n_push = 4'd0;
    endcase
  end

  // Output view of the FIFO head, pop, append and control next-state
  always_comb begin
    out_vld = 4'h0;
    if (fill_p0 >= FW'(4)) out_vld = 4'hF;
    else if (state_p0 == FLUSH) begin
      case (fill_p0[1:0])
        2'd1:    out_vld = 4'b0001;
        2'd2:    out_vld = 4'b0011;
        2'd3:    out_vld = 4'b0111;
        default: out_vld = 4'b0000;
      endcase
    end
    pop = 3'd0;
    if (bus.byte_ready_i) begin
      case (out_vld)
        4'b1111: pop = 3'd4;
        4'b0111: pop = 3'd3;
        4'b0011: pop = 3'd2;
        4'b0001: pop = 3'd1;
        default: pop = 3'd0;
      endcase
    end
    base = fill_p0 - FW'(pop);
    for (int i = 0; i < BUF_BYTES; i++) begin
      int idx, off;
      idx = i + int'(pop);
      off = i - int'(base);
      buf_nxt[i] = (idx < BUF_BYTES) ? buf_p0[idx[AW-1:0]] : 8'h00;
      if (accept && off >= 0 && off < int'(n_push)) buf_nxt[i] = beat_bytes[off[3:0]];
    end
    fill_nxt = base + (accept ? FW'(n_push) : FW'(0));
    state_nxt = state_p0;
    case (state_p0)
      RUN:     if (bus.flush_i) state_nxt = FLUSH;
      FLUSH:   if (fill_nxt == FW'(0)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      state_p0    <= RUN;
      fill_p0     <= '0;
      ready_p0    <= 1'b1;
      err_p0      <= 1'b0;
      lock_vld_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      fill_p0  <= fill_nxt;
      ready_p0 <= (state_nxt == RUN) && (fill_nxt <= FW'(BUF_BYTES - 12));
      err_p0   <= drop;
      if (state_p0 == FLUSH && state_nxt == RUN) lock_vld_p0 <= 1'b0;
      else if (accept)                           lock_vld_p0 <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_i) begin
    buf_p0 <= buf_nxt;
    if (accept) lock_type_p0 <= dt;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) bus.byte_data_o[8*i +: 8] = out_vld[i] ? buf_p0[i] : 8'h00;
  end

  assign bus.byte_data_valid_o = out_vld;
  assign bus.pixel_ready_o     = ready_p0;
  assign bus.busy_o            = (fill_p0 != FW'(0)) || (state_p0 == FLUSH);
  assign bus.error_o           = err_p0;
endmodule

// File: tb/tb_pixel_byte_packer.sv
// Scoreboard bench for pixel_byte_packer: directed beats push expected words into a
// queue, a negedge monitor pops and compares every word the packer hands over.
module tb_pixel_byte_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_byte_packer_if bus();
  pixel_byte_packer #(.BUF_BYTES(16)) dut (.pixel_clk_i(clk), .reset_i(rst), .bus(bus));

  localparam logic [5:0] YUV = 6'h1E, RGB888 = 6'h24, RGB565 = 6'h22, RAW8 = 6'h2A, RAW10 = 6'h2B;

  typedef struct packed { logic [31:0] data; logic [3:0] vld; } word_t;
  word_t exp_q[$];
  word_t w_m;
  int checks = 0, failures = 0, err_cnt = 0, words_seen = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.error_o) err_cnt++;
      if (bus.byte_data_valid_o != 4'h0 && bus.byte_ready_i) begin
        words_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word actual=%h/%b required=none", bus.byte_data_o, bus.byte_data_valid_o);
        end else begin
          w_m = exp_q.pop_front();
          if (bus.byte_data_o !== w_m.data || bus.byte_data_valid_o !== w_m.vld) begin
            failures++;
            $display("FAIL word actual=%h/%b required=%h/%b", bus.byte_data_o, bus.byte_data_valid_o, w_m.data, w_m.vld);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] v);
    word_t w;
    w.data = d;
    w.vld  = v;
    exp_q.push_back(w);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [5:0] dt, input logic [2:0] ppc, input logic [95:0] d,
                           input logic [3:0] s, output int acc_cyc);
    int n;
    bus.data_type_i = dt;
    bus.pixel_per_clk_i = ppc;
    bus.pixel_data_i = d;
    bus.pixel_data_valid_i = s;
    n = 0;
    while (!bus.pixel_ready_o && n < 50) begin step(1); n++; end
    chk("beat_accept_ready", 32'(bus.pixel_ready_o), 32'd1);
    acc_cyc = cyc;
    step(1);
    bus.pixel_data_valid_i = 4'h0;
  endtask

  task automatic drop_beat(input string name, input logic [5:0] dt, input logic [2:0] ppc,
                           input logic [95:0] d, input logic [3:0] s);
    int e0;
    e0 = err_cnt;
    bus.data_type_i = dt;
    bus.pixel_per_clk_i = ppc;
    bus.pixel_data_i = d;
    bus.pixel_data_valid_i = s;
    step(1);
    bus.pixel_data_valid_i = 4'h0;
    step(2);
    chk({name, "_error_pulses"}, 32'(err_cnt - e0), 32'd1);
    chk({name, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({name, "_ready"}, 32'(bus.pixel_ready_o), 32'd1);
  endtask

  task automatic do_flush(input string name);
    int n;
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    n = 0;
    while (bus.busy_o && n < 100) begin step(1); n++; end
    chk({name, "_flush_done"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    logic [95:0] d;
    int ac, aprev, e0, w0;
    rst = 1'b1;
    bus.data_type_i = RAW8;
    bus.pixel_per_clk_i = 3'd4;
    bus.pixel_data_i = '0;
    bus.pixel_data_valid_i = 4'h0;
    bus.flush_i = 1'b0;
    bus.byte_ready_i = 1'b1;
    step(3);
    chk("reset_valid", 32'(bus.byte_data_valid_o), 32'h0);
    chk("reset_data", bus.byte_data_o, 32'h0);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_error", 32'(bus.error_o), 32'd0);
    chk("reset_ready", 32'(bus.pixel_ready_o), 32'd1);
    rst = 1'b0;
    step(1);

    // RAW8, four lanes, bytes 00..0F with junk in the ignored upper bits
    w0 = words_seen;
    push_word(32'h03020100, 4'hF);
    push_word(32'h07060504, 4'hF);
    push_word(32'h0B0A0908, 4'hF);
    push_word(32'h0F0E0D0C, 4'hF);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) d[24*k +: 24] = {16'hABCD, 8'(4*b + k)};
      send_beat(RAW8, 3'd4, d, 4'hF, ac);
      if (b == 0) begin
        chk("raw8_first_word_valid", 32'(bus.byte_data_valid_o), 32'hF);
        chk("raw8_first_word_data", bus.byte_data_o, 32'h03020100);
      end
    end
    step(3);
    chk("raw8_word_count", 32'(words_seen - w0), 32'd4);
    chk("raw8_drained_valid", 32'(bus.byte_data_valid_o), 32'h0);
    do_flush("raw8");

    // RAW10 packing with a partial tail drained by flush
    push_word(32'h55AA00FF, 4'hF);
    push_word(32'hAA00FF63, 4'hF);
    push_word(32'h00006355, 4'b0011);
    d = {14'h1234, 10'h155, 14'h1234, 10'h2AA, 14'h1234, 10'h000, 14'h1234, 10'h3FF};
    send_beat(RAW10, 3'd4, d, 4'hF, ac);
    send_beat(RAW10, 3'd4, d, 4'hF, ac);
    step(2);
    chk("raw10_busy_partial", 32'(bus.busy_o), 32'd1);
    chk("raw10_no_partial_in_run", 32'(bus.byte_data_valid_o), 32'h0);
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    chk("raw10_tail_valid", 32'(bus.byte_data_valid_o), 32'h3);
    chk("raw10_tail_busy", 32'(bus.busy_o), 32'd1);
    chk("raw10_tail_noready", 32'(bus.pixel_ready_o), 32'd0);
    step(1);
    chk("raw10_busy_after_pop", 32'(bus.busy_o), 32'd0);
    chk("raw10_ready_after_pop", 32'(bus.pixel_ready_o), 32'd1);

    // RGB888, continuous beats: one accept every 3 cycles, gapless output
    w0 = words_seen;
    for (int w = 0; w < 9; w++)
      push_word({8'(8'h23 + 4*w), 8'(8'h22 + 4*w), 8'(8'h21 + 4*w), 8'(8'h20 + 4*w)}, 4'hF);
    aprev = 0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 3; j++) d[24*k + 8*j +: 8] = 8'(8'h20 + 12*b + 3*k + j);
      send_beat(RGB888, 3'd4, d, 4'hF, ac);
      if (b > 0) chk("rgb888_beat_spacing", 32'(ac - aprev), 32'd3);
      aprev = ac;
    end
    chk("rgb888_words_midway", 32'(words_seen - w0), 32'd6);
    step(3);
    chk("rgb888_words_total", 32'(words_seen - w0), 32'd9);
    chk("rgb888_drained_valid", 32'(bus.byte_data_valid_o), 32'h0);
    do_flush("rgb888");

    // Output stall: head word held, acceptance stops, lossless resume
    push_word(32'h43424140, 4'hF);
    push_word(32'h47464544, 4'hF);
    push_word(32'h4B4A4948, 4'hF);
    bus.byte_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) d[24*k +: 24] = {16'h0, 8'(8'h40 + 4*b + k)};
      send_beat(RAW8, 3'd4, d, 4'hF, ac);
    end
    for (int k = 0; k < 4; k++) d[24*k +: 24] = {16'h0, 8'(8'h48 + k)};
    bus.pixel_data_i = d;
    bus.pixel_data_valid_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("stall_hold_data", bus.byte_data_o, 32'h43424140);
      chk("stall_hold_valid", 32'(bus.byte_data_valid_o), 32'hF);
      chk("stall_no_ready", 32'(bus.pixel_ready_o), 32'd0);
    end
    bus.byte_ready_i = 1'b1;
    send_beat(RAW8, 3'd4, d, 4'hF, ac);
    step(3);
    do_flush("stall");

    // Dropped beats
    drop_beat("raw10_strobe0111", RAW10, 3'd4, 96'h0, 4'b0111);
    push_word(32'h22811180, 4'hF);
    send_beat(YUV, 3'd2, {48'h0, 8'hEE, 16'h2281, 8'hEE, 16'h1180}, 4'b0011, ac);
    step(2);
    drop_beat("locked_rgb565", RGB565, 3'd2, {48'h0, 8'h00, 16'hCAFE, 8'h00, 16'hBEEF}, 4'b0011);
    do_flush("yuv");
    e0 = err_cnt;
    push_word(32'hCAFEBEEF, 4'hF);
    send_beat(RGB565, 3'd2, {48'h0, 8'h00, 16'hCAFE, 8'h00, 16'hBEEF}, 4'b0011, ac);
    step(2);
    chk("rgb565_after_flush_no_error", 32'(err_cnt - e0), 32'd0);
    drop_beat("strobe0101", RGB565, 3'd4, 96'h0, 4'b0101);
    do_flush("errors");

    // Reset while flushing with 7 bytes held
    bus.byte_ready_i = 1'b0;
    send_beat(RAW8, 3'd4, 96'h0000_0000_0062_0000_6100_0060, 4'b0111, ac);
    send_beat(RAW8, 3'd4, 96'h0000_6600_0065_0000_6400_0063, 4'hF, ac);
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    chk("flush7_busy", 32'(bus.busy_o), 32'd1);
    chk("flush7_head", bus.byte_data_o, 32'h63626160);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midreset_valid", 32'(bus.byte_data_valid_o), 32'h0);
    chk("midreset_busy", 32'(bus.busy_o), 32'd0);
    chk("midreset_ready", 32'(bus.pixel_ready_o), 32'd1);
    bus.byte_ready_i = 1'b1;
    e0 = err_cnt;
    push_word(32'h56781234, 4'hF);
    send_beat(RGB565, 3'd2, {48'h0, 8'h00, 16'h5678, 8'h00, 16'h1234}, 4'b0011, ac);
    step(2);
    chk("midreset_new_type_no_error", 32'(err_cnt - e0), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_byte_packer.md
Name: pixel_byte_packer

Overview:
Transmit-side counterpart of flow_control. It packs a parallel pixel stream (1/2/4 pixels per clock, up to 24 bits per pixel lane) into a CSI-2 style 4-byte-lane payload stream, using the CSI-2 byte ordering for each data type. It feeds the packet builder / test-pattern path of the CSI-2 transmitter and runs in the pixel clock domain. It provides backpressure on both sides and explicit flushing of end-of-line partial words.

Parameters:
BUF_BYTES, 16, byte buffer capacity. Must be at least 16 (12 worst-case beat bytes + 4 output bytes).

Ports:
pixel_clk_i  input  1  single clock; all logic on the rising edge
reset_i  input  1  synchronous, active-high reset
data_type_i  input  6  1E YUV422_8, 24 RGB888, 22 RGB565, 2A RAW8, 2B RAW10
pixel_per_clk_i  input  3  1, 2 or 4; lanes at or above this count are ignored
pixel_data_i  input  96  4 pixel lanes of 24 bits; lane k = [24k+23:24k]
pixel_data_valid_i  input  4  per-lane strobe; must be contiguous from lane 0
pixel_ready_o  output  1  beat accepted when ready=1 and the masked strobe is nonzero
flush_i  input  1  pulse; drain all buffered bytes, including a partial word
byte_data_o  output  32  byte lane 0 = [7:0] = earliest byte
byte_data_valid_o  output  4  per-byte valid; 4'hF for full words, low-contiguous on a flush tail
byte_ready_i  input  1  word consumed when any valid bit is set and ready=1
busy_o  output  1  buffer non-empty or in FLUSH
error_o  output  1  one-cycle pulse when a beat is dropped

Behaviour:
- Bytes emitted per accepted pixel, low byte first:
  - RAW8: lane[7:0].
  - RGB565: lane[7:0], then lane[15:8].
  - YUV422_8: lane[7:0] (chroma), then lane[15:8] (luma).
  - RGB888: lane[7:0], then [15:8], then [23:16].
  - RAW10: whole beat only. Emits p0[9:2], p1[9:2], p2[9:2], p3[9:2], then {p3[1:0], p2[1:0], p1[1:0], p0[1:0]}.
- Beats from lanes 0..n-1 append in lane order to a BUF_BYTES byte buffer (FIFO of bytes, fill counter 0..BUF_BYTES).
- pixel_ready_o = (state==RUN) && (fill <= BUF_BYTES-12). It is registered, derived from the fill at the start of the cycle.
- Output is the combinational view of the 4 head bytes. A byte accepted at edge N is visible after edge N.
  - In RUN: valid = 4'hF when fill >= 4, else 0.
  - In FLUSH: valid = 4'hF when fill >= 4; otherwise the low fill bits are set (e.g. fill=2 gives 4'b0011) and the unused bytes are driven 0.
- Output hold: byte_data_o and byte_data_valid_o stay stable while valid != 0 and byte_ready_i = 0.
- Simultaneous push and pop are allowed in the same cycle: fill_next = fill + pushed - popped. Overflow cannot occur given the ready rule.
- Format lock: the first accepted beat after reset or after a flush latches data_type_i. A later beat with a different type is dropped and pulses error_o.
- Other dropped beats (each pulses error_o, buffer unchanged, ready unaffected):
  - unsupported data_type_i
  - pixel_per_clk_i not in {1, 2, 4}
  - non-contiguous strobe
  - RAW10 with a masked strobe other than 4'hF (this requires ppc = 4)
- FSM:
  - RUN to FLUSH on flush_i. A beat presented in the same cycle as flush_i is accepted first if ready.
  - In FLUSH, pixel_ready_o = 0.
  - FLUSH to RUN when fill reaches 0 through a pop. This clears the format lock.
  - flush_i with fill = 0 goes to FLUSH for one cycle, then back to RUN.
  - flush_i while already in FLUSH is ignored.
- Reset (synchronous, mid-operation included): discards the buffer, sets fill = 0, enters RUN and clears the lock.
- Reset values: byte_data_o 0, byte_data_valid_o 0, busy_o 0, error_o 0, pixel_ready_o 1.

Test Plan:
1. RAW8, ppc=4, byte_ready_i=1, beats carrying bytes 00..0F -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, all with valid F. The first word appears one cycle after the first accept. No gaps, no duplicates.
2. RAW10, ppc=4, two beats with pixels {3FF, 000, 2AA, 155}, then flush_i -> 0x55AA00FF (F), 0xAA00FF63 (F), 0x00006355 (valid 0011). busy_o falls after the last pop.
3. RGB888, ppc=4, continuous beats, byte_ready_i=1 -> pixel_ready_o holds 1 beat per 3 cycles. The output is a gapless stream of 12 bytes per beat in B,G,R lane order.
4. Stall: a word is present and byte_ready_i=0 for 5 cycles -> byte_data_o and byte_data_valid_o are unchanged. Accepted beats stop once fill > BUF_BYTES-12. The stream resumes losslessly on release.
5. Errors (each gives one error_o pulse, fill unchanged):
   - RAW10 with strobe 0111.
   - YUV422_8 locked, then an RGB565 beat is dropped; after flush completes, the same RGB565 beat is accepted.
   - Strobe 0101.
6. Reset asserted with 7 bytes buffered in FLUSH -> next cycle valid=0, busy_o=0, pixel_ready_o=1, and a new data type is accepted without error.
